// File: rtl/config_chain_pkg.sv
// config_chain_pkg: shared types and constants for the configuration scan-chain
// loader.
//   ccl_state_t  loader FSM state (IDLE, LOAD, SHIFT, DONE)
//   CRC8_POLY    CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   CRC8_INIT    CRC-8 initial/cleared value
//   crc8_step    one bit-serial CRC-8 update, MSB-first
package config_chain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccl_state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // Feedback is the outgoing MSB xor the incoming bit; when it is set, the
  // polynomial is folded into the shifted register.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/config_chain_crc8.sv
// config_chain_crc8: bit-serial CRC-8 register over the bits driven into the
// scan chain.
// Ports:
//   CK      clock (shared with the chain)
//   RST     synchronous active-high reset, returns crc to CRC8_INIT
//   clr     synchronous clear to CRC8_INIT (wins over en)
//   en      fold bit_in into the CRC this cycle
//   bit_in  serial data bit
//   crc     current CRC value (registered)
module config_chain_crc8
  import config_chain_pkg::*;
(
  input  logic       CK,
  input  logic       RST,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr)     crc_d = CRC8_INIT;
    else if (en) crc_d = crc8_step(crc_q, bit_in);
  end

  always_ff @(posedge CK) begin
    if (RST) crc_q <= CRC8_INIT;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/config_chain_loader.sv
// config_chain_loader: serial loader for a configuration scan chain. Accepts
// WORD_W-bit words over valid/ready, shifts each MSB-first onto SE/SI and stops
// after exactly CHAIN_LEN shift cycles, discarding any leftover word bits.
// Optional feature: define CONFIG_CHAIN_CRC_EN to add a CRC-8 of every bit
// shifted into the chain (output crc).
// Ports:
//   CK         clock, shared with the chain flops
//   RST        synchronous active-high reset
//   start      begin a load (honoured only in IDLE or DONE)
//   din        configuration word, bit WORD_W-1 shifted first
//   din_valid  din holds a valid word
//   din_ready  word is accepted this cycle (high throughout LOAD)
//   SE, SI     scan enable / scan data to the chain head
//   busy       load in progress (LOAD or SHIFT)
//   done       chain fully loaded; held until start or RST
//   crc        (CONFIG_CHAIN_CRC_EN only) CRC-8 over shifted bits
module config_chain_loader
  import config_chain_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              SE,
  output logic              SI,
  output logic              busy,
  output logic              done
`ifdef CONFIG_CHAIN_CRC_EN
  ,
  output logic [7:0]        crc
`endif
);

  localparam int CW  = $clog2(CHAIN_LEN + 1);
  localparam int WCW = $clog2(WORD_W + 1);
  // bit_cnt value during the final shift cycle; the increment out of it
  // reaches CHAIN_LEN, so the counter never wraps.
  localparam logic [CW-1:0]  BIT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [WCW-1:0] WORD_LEN = WCW'(WORD_W);
  localparam logic [WCW-1:0] WC_ONE   = WCW'(1);

  ccl_state_t        state_q;
  logic [WORD_W-1:0] shreg_q;
  logic [CW-1:0]     bit_cnt_q;
  logic [WCW-1:0]    word_cnt_q;
  logic              din_ready_q, se_q, busy_q, done_q;

  // Outputs are registered alongside the state so nothing depends
  // combinationally on the inputs.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      din_ready_q <= 1'b0;
      se_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= LOAD;
            bit_cnt_q   <= '0;
            din_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end
        LOAD: begin
          // din_ready is high for the whole LOAD state, so valid alone
          // completes the handshake.
          if (din_valid) begin
            state_q     <= SHIFT;
            shreg_q     <= din;
            word_cnt_q  <= WORD_LEN;
            din_ready_q <= 1'b0;
            se_q        <= 1'b1;
          end
        end
        SHIFT: begin
          shreg_q    <= shreg_q << 1;
          bit_cnt_q  <= bit_cnt_q + CW'(1);
          word_cnt_q <= word_cnt_q - WC_ONE;
          // Chain-full wins over word-empty: leftover word bits are dropped.
          if (bit_cnt_q == BIT_LAST) begin
            state_q <= DONE;
            se_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (word_cnt_q == WC_ONE) begin
            state_q     <= LOAD;
            se_q        <= 1'b0;
            din_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          din_ready_q <= 1'b0;
          se_q        <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign din_ready = din_ready_q;
  assign SE        = se_q;
  // Gated so the chain head sees 0 whenever it is not shifting.
  assign SI        = se_q & shreg_q[WORD_W-1];
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef CONFIG_CHAIN_CRC_EN
  logic crc_clr;
  // Clear on the LOAD entry that begins a new chain load.
  assign crc_clr = start & ((state_q == IDLE) | (state_q == DONE));

  config_chain_crc8 u_crc (
    .CK     (CK),
    .RST    (RST),
    .clr    (crc_clr),
    .en     (se_q),
    .bit_in (SI),
    .crc    (crc)
  );
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
module tb_config_chain_loader;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic       rst   [2];
  logic       start [2];
  logic       valid [2];
  logic [7:0] din   [2];
  logic       ready [2];
  logic       se    [2];
  logic       si    [2];
  logic       busy  [2];
  logic       done  [2];
`ifdef CONFIG_CHAIN_CRC_EN
  logic [7:0] crc   [2];
`endif

  // DUT 0: default geometry; DUT 1: short chain with a partial last word.
  config_chain_loader #(.WORD_W(8), .CHAIN_LEN(64)) u_dut0 (
    .CK(CK), .RST(rst[0]), .start(start[0]), .din(din[0]), .din_valid(valid[0]),
    .din_ready(ready[0]), .SE(se[0]), .SI(si[0]), .busy(busy[0]), .done(done[0])
`ifdef CONFIG_CHAIN_CRC_EN
    , .crc(crc[0])
`endif
  );

  config_chain_loader #(.WORD_W(8), .CHAIN_LEN(12)) u_dut1 (
    .CK(CK), .RST(rst[1]), .start(start[1]), .din(din[1]), .din_valid(valid[1]),
    .din_ready(ready[1]), .SE(se[1]), .SI(si[1]), .busy(busy[1]), .done(done[1])
`ifdef CONFIG_CHAIN_CRC_EN
    , .crc(crc[1])
`endif
  );

  // Model scan chains: bit 0 is the head flop, bit L-1 the tail.
  logic [63:0] chain [2];
  always @(posedge CK) begin
    for (int d = 0; d < 2; d++)
      if (se[d] === 1'b1) chain[d] <= {chain[d][62:0], si[d]};
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic int len_of(input int d);
    return (d == 0) ? 64 : 12;
  endfunction

  // Expected chain image: the first L bits of the MSB-first stream, the
  // first bit landing in the tail flop.
  function automatic logic [63:0] m_chain(input int L, input logic [7:0][7:0] w);
    logic [63:0] r = '0;
    for (int i = 0; i < L; i++) r[L-1-i] = w[i/8][7-(i%8)];
    return r;
  endfunction

  // Cycles from start sample to done: one to reach LOAD, then per word its
  // stall cycles, one accept cycle and the bits it actually shifts.
  function automatic int m_cycles(input int L, input logic [7:0][7:0] g);
    int c = 1;
    int nw = (L + 7) / 8;
    for (int k = 0; k < nw; k++) c += int'(g[k]) + 1 + ((L - 8*k < 8) ? (L - 8*k) : 8);
    return c;
  endfunction

  // CRC-8 as polynomial division of the message bits (poly 0x107).
  function automatic logic [7:0] m_crc(input int L, input logic [7:0][7:0] w);
    logic [8:0] r = '0;
    for (int i = 0; i < L + 8; i++) begin
      r = {r[7:0], (i < L) ? w[i/8][7-(i%8)] : 1'b0};
      if (r[8]) r = r ^ 9'h107;
    end
    return r[7:0];
  endfunction

  task automatic run_load(input int d, input int nw, input logic [7:0][7:0] w,
                          input logic [7:0][7:0] g, input int spulse, input bit junk,
                          input int rst_cyc, output int cyc, output int se_cnt,
                          output bit stall_bad);
    int k = 0;
    int gap = int'(g[0]);
    cyc = 0; se_cnt = 0; stall_bad = 0;
    start[d] = 1'b1; valid[d] = 1'b0;
    @(negedge CK);
    start[d] = 1'b0; cyc = 1;
    chk("start_ack", {62'd0, done[d], busy[d]}, 64'd1);
    while (done[d] !== 1'b1 && cyc < 300) begin
      if (se[d] === 1'b1) se_cnt++;
      if (rst_cyc != 0 && cyc == rst_cyc) begin
        chk("rst_in_shift", {63'd0, se[d]}, 64'd1);
        rst[d] = 1'b1;
        @(negedge CK);
        rst[d] = 1'b0;
        return;
      end
      start[d] = (cyc == spulse);
      if (ready[d] === 1'b1) begin
        if (gap > 0) begin
          gap--;
          valid[d] = 1'b0;
          if (se[d] !== 1'b0) stall_bad = 1'b1;
        end else if (k < nw) begin
          valid[d] = 1'b1;
          din[d] = w[k];
          k++;
          gap = (k < 8) ? int'(g[k]) : 0;
        end else valid[d] = 1'b0;
      end else begin
        valid[d] = junk ? 1'($urandom) : 1'b0;
        din[d] = 8'($urandom);
      end
      @(negedge CK);
      cyc++;
    end
    start[d] = 1'b0; valid[d] = 1'b0;
    if (done[d] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL timeout dut%0d cyc=%0d", d, cyc);
    end
  endtask

  typedef struct {
    int              d;
    logic [7:0][7:0] w;
    logic [7:0][7:0] g;
    int              spulse;
    bit              junk;
    int              exp_cyc;
    logic [63:0]     exp_chain;
    int              exp_se;
  } vec_t;

  task automatic check_result(input string tag, input int d, input logic [7:0][7:0] w,
                              input int cyc, input int exp_cyc, input logic [63:0] exp_ch,
                              input int se_cnt, input int exp_se, input bit stall_bad);
    logic [63:0] mask = (d == 0) ? '1 : 64'hFFF;
    chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_chain"}, chain[d] & mask, exp_ch);
    chk({tag, "_se_cnt"}, 64'(se_cnt), 64'(exp_se));
    chk({tag, "_stall_se"}, {63'd0, stall_bad}, 64'd0);
    chk({tag, "_done_state"}, {61'd0, done[d], busy[d], ready[d]}, 64'd4);
`ifdef CONFIG_CHAIN_CRC_EN
    chk({tag, "_crc"}, {56'd0, crc[d]}, {56'd0, m_crc(len_of(d), w)});
`else
    if (w === 64'hx) $display("unreachable");
`endif
  endtask

  initial begin
    vec_t tbl[6];
    int cyc, se_cnt;
    bit sb;
    logic [7:0][7:0] w, g;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; valid[d] = 1'b0; din[d] = '0; chain[d] = '0;
    end
    // start held with RST: RST must win.
    start[0] = 1'b1;
    repeat (3) @(negedge CK);
    for (int d = 0; d < 2; d++) begin
      chk("reset_outs", {59'd0, ready[d], se[d], si[d], busy[d], done[d]}, 64'd0);
      rst[d] = 1'b0;
    end
    start[0] = 1'b0;
    @(negedge CK);
    chk("idle_hold", {62'd0, busy[0], done[0]}, 64'd0);

    tbl[0] = '{0, {8'h08,8'h07,8'h06,8'h05,8'h04,8'h03,8'h02,8'h01}, '0, 0, 0,
               73, 64'h0102030405060708, 64};
    tbl[1] = '{0, {8'h08,8'h07,8'h06,8'h05,8'h04,8'h03,8'h02,8'h01},
               {8'd0,8'd0,8'd0,8'd0,8'd0,8'd5,8'd0,8'd0}, 0, 0,
               78, 64'h0102030405060708, 64};
    tbl[2] = '{1, {48'd0, 8'hFF, 8'hA5}, '0, 0, 0, 15, 64'hA5F, 12};
    tbl[3] = '{0, {8'h10,8'h20,8'h30,8'h40,8'h50,8'h60,8'h70,8'h80}, '0, 20, 1,
               73, 64'h8070605040302010, 64};
    tbl[4] = '{1, {48'd0, 8'h0F, 8'h3C}, {48'd0, 8'd3, 8'd2}, 0, 1, 20, 64'h3C0, 12};
    tbl[5] = '{0, '0, '0, 0, 0, 73, 64'h0, 64};

    for (int i = 0; i < 6; i++) begin
      run_load(tbl[i].d, (len_of(tbl[i].d) + 7) / 8, tbl[i].w, tbl[i].g, tbl[i].spulse,
               tbl[i].junk, 0, cyc, se_cnt, sb);
      check_result($sformatf("vec%0d", i), tbl[i].d, tbl[i].w, cyc, tbl[i].exp_cyc,
                   tbl[i].exp_chain, se_cnt, tbl[i].exp_se, sb);
      @(negedge CK);
      chk("done_held", {63'd0, done[tbl[i].d]}, 64'd1);
    end

    // Reset during the 3rd shift cycle of word 4, then a clean reload.
    w = {8'hEE,8'hDD,8'hCC,8'hBB,8'hAA,8'h99,8'h88,8'h77};
    run_load(0, 8, w, '0, 0, 0, 31, cyc, se_cnt, sb);
    chk("rst_outs", {59'd0, ready[0], se[0], si[0], busy[0], done[0]}, 64'd0);
    @(negedge CK);
    chk("rst_idle", {62'd0, busy[0], done[0]}, 64'd0);
    run_load(0, 8, w, '0, 0, 0, 0, cyc, se_cnt, sb);
    check_result("after_rst", 0, w, cyc, 73, 64'h7788_99AA_BBCC_DDEE, se_cnt, 64, sb);

    // Randomized loads against the stream model.
    for (int it = 0; it < 20; it++) begin
      int d = int'($urandom_range(0, 1));
      int L = len_of(d);
      bit jk = 1'($urandom);
      for (int k = 0; k < 8; k++) begin
        w[k] = 8'($urandom);
        g[k] = 8'($urandom_range(0, 3));
      end
      run_load(d, (L + 7) / 8, w, g, 0, jk, 0, cyc, se_cnt, sb);
      check_result($sformatf("rand%0d", it), d, w, cyc, m_cycles(L, g), m_chain(L, w),
                   se_cnt, L, sb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
# config_chain_loader

Serial loader for a configuration scan chain built from the scan-enabled D flip-flop cells. The block accepts configuration words from a bitstream source over a valid/ready handshake. It serializes each word MSB-first onto the chain's SE/SI pins and counts exactly CHAIN_LEN shift cycles. It then flags completion. It sits directly upstream of the chain head, and the chain flops share CK with it.

## Interface
- WORD_W, default 8: width of incoming bitstream words; ≥1.
- CHAIN_LEN, default 64: number of flops in the driven chain; ≥1.
- CK  input  1  clock; shared with the scan-chain flops.
- RST  input  1  reset; one clock, reset is synchronous and active-high.
- start  input  1  begin a load; sampled only in IDLE or DONE.
- din  input  WORD_W  configuration word; bit WORD_W-1 is shifted first.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  block accepts din this cycle.
- SE  output  1  scan enable to the chain head.
- SI  output  1  scan data to the chain head.
- busy  output  1  high in LOAD or SHIFT.
- done  output  1  high in DONE; held until start or RST.

## Operation
- States (package enum): IDLE, LOAD, SHIFT, DONE.
- IDLE: start=1 → LOAD, and clear bit_cnt.
- LOAD: din_ready=1. On din_valid & din_ready:
  - shreg ← din, word_cnt ← WORD_W, go to SHIFT.
  - With no valid word, stay in LOAD (stall); SE=0, so the chain holds.
- SHIFT: SE=1, SI=shreg[WORD_W-1]. Each cycle:
  - shift shreg left by one, bit_cnt++, word_cnt--.
  - Exit when the post-increment bit_cnt==CHAIN_LEN → DONE. This takes priority, and any unshifted word bits are discarded.
  - Otherwise, exit when word_cnt reaches 0 → LOAD.
- DONE: done=1, SE=0.
  - start=1 → LOAD with bit_cnt cleared, and done drops the next cycle.
- start is ignored in LOAD and SHIFT.
- din_valid outside LOAD is ignored; the word is not consumed.
- bit_cnt width: $clog2(CHAIN_LEN+1). It never exceeds CHAIN_LEN and never wraps.
- Word count per load: ceil(CHAIN_LEN/WORD_W).
- RST at any time (including mid-SHIFT) → IDLE, with shreg, bit_cnt and word_cnt cleared. Chain contents are left partially loaded and are not restored.
- RST asserted together with start: RST wins.

## Timing
- Reset values: din_ready=0, SE=0, SI=0, busy=0, done=0.
- All outputs are decoded directly from registers (state, shreg), with no combinational path from inputs. Exception: din_ready, which is state-only.
- Handshake accepted at edge N → SE=1 during cycles N+1..N+WORD_W. The chain flop samples SI at the end of each SE cycle.
- Cost per word: 1 LOAD cycle + WORD_W SHIFT cycles, for back-to-back valid input.
- Defaults (CHAIN_LEN=64, WORD_W=8), start at edge 0, din_valid held high:
  - done rises 73 cycles after start is sampled.
  - That is 1 IDLE→LOAD + 8×(1+8).
- The first bit shifted ends in the last chain flop (flop CHAIN_LEN-1).

## Configuration
- Macro: CONFIG_CHAIN_CRC_EN.
- Defined:
  - Adds output crc[7:0], which is CRC-8 with poly 0x07 and init 0x00, over every bit driven on SI while SE=1, in shift order.
  - crc clears on the LOAD entry from IDLE/DONE and on RST.
  - crc is stable in DONE.
- Undefined: no crc port and no CRC logic.

## Structure
- Package config_chain_pkg holds:
  - the state enum (ccl_state_t);
  - CRC8_POLY = 8'h07;
  - CRC8_INIT = 8'h00.
- Sub-module config_chain_crc8 holds the bit-serial CRC register (CK, RST, clr, en, bit_in, crc). It is instantiated only under CONFIG_CHAIN_CRC_EN.
- Top-level holds the FSM, counters and shreg.

## Test plan
- Full load: CHAIN_LEN=64, WORD_W=8, eight words 0x01..0x08 with valid held.
  - done after 73 cycles.
  - A model 64-flop chain holds 0x08..0x01 from head to tail.
  - SE is high for exactly 64 cycles.
- Partial last word: CHAIN_LEN=12, WORD_W=8, words 0xA5, 0xFF.
  - Only 0xF's upper 4 bits are shifted, and done follows the 12th SE cycle.
  - The chain reads 1010_0101_1111.
- Stall: din_valid low for 5 cycles between words 2 and 3.
  - SE stays 0 throughout the stall, and the chain contents are unchanged.
  - Final contents are identical to the no-stall run; done is delayed by 5 cycles.
- Reset mid-shift: RST pulsed at the 3rd SHIFT cycle of word 4.
  - Next cycle: IDLE, all outputs at reset values.
  - A new start then completes normally in 73 cycles.
- Restart/ignored inputs:
  - start pulsed during SHIFT → no effect.
  - start in DONE → done low the next cycle, and a second load completes.
- CRC (macro defined): all-zero bitstream → crc=0x00 at DONE. A single word 0x01 with CHAIN_LEN=8 → crc=0x07.
